maneuver_sequencer: RTL

//  Sequences the cart's motor driver. Accepts motion commands over valid/ready and drives the 3-bit motor mode.

---
 rtl/maneuver_pkg.sv | 67 ++++++
 rtl/tick_prescaler.sv | 40 ++++
 rtl/maneuver_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/maneuver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : maneuver_pkg
// Description : Shared types for the cart manoeuvre sequencer. Holds the motor
//               mode codes, the command codes, the sequencer state encoding and
//               the helpers mapping a command/state onto a motor mode and a
//               manoeuvre duration.
// Revision    : 1.0 - initial release
// ============================================================================
package maneuver_pkg;

    // Motor-mode codes presented to the motor block
    localparam logic [2:0] c_MODE_STOP  = 3'b000;
    localparam logic [2:0] c_MODE_RIGHT = 3'b001;
    localparam logic [2:0] c_MODE_LEFT  = 3'b010;
    localparam logic [2:0] c_MODE_FWD   = 3'b011;
    localparam logic [2:0] c_MODE_BACK  = 3'b100;

    typedef enum logic [2:0] {
        CMD_STOP   = 3'd0,
        CMD_FWD    = 3'd1,
        CMD_BACK   = 3'd2,
        CMD_TURN_L = 3'd3,
        CMD_TURN_R = 3'd4,
        CMD_UTURN  = 3'd5,
        CMD_ROT_L  = 3'd6,
        CMD_ROT_R  = 3'd7
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN_CONT  = 3'd1,
        ST_RUN_TIMED = 3'd2,
        ST_BACKOFF   = 3'd3,
        ST_HOLD      = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    // Motor mode driven while sitting in a state with a given active command
    function automatic logic [2:0] state_mode(input state_t st, input cmd_t cmd);
        logic [2:0] m;
        m = c_MODE_STOP;
        case (st)
            ST_RUN_CONT:  m = (cmd == CMD_BACK) ? c_MODE_BACK : c_MODE_FWD;
            ST_RUN_TIMED: m = ((cmd == CMD_TURN_R) || (cmd == CMD_ROT_R)) ? c_MODE_RIGHT : c_MODE_LEFT;
            ST_BACKOFF:   m = c_MODE_BACK;
            default:      m = c_MODE_STOP;
        endcase
        return m;
    endfunction

    // Duration in ticks of a timed manoeuvre (0 for untimed commands)
    function automatic int cmd_duration(input cmd_t cmd, input int turn_t,
                                        input int uturn_t, input int rot_t);
        int d;
        d = 0;
        case (cmd)
            CMD_TURN_L, CMD_TURN_R: d = turn_t;
            CMD_UTURN:              d = uturn_t;
            CMD_ROT_L, CMD_ROT_R:   d = rot_t;
            default:                d = 0;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Divides clk down to a one-cycle duration tick every TICK_DIV
//               cycles while run is high. clear returns the count to 0 and
//               takes priority over counting.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int c_PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PS_W-1:0] c_LAST = c_PS_W'(TICK_DIV - 1);
    localparam logic [c_PS_W-1:0] c_ONE  = c_PS_W'(1);

    logic [c_PS_W-1:0] r_count;

    // Count 0..TICK_DIV-1 while running, wrapping on the last value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (run) begin
            r_count <= (r_count == c_LAST) ? '0 : r_count + c_ONE;
        end
    end

    // Tick is independent of clear so the sequencer can use it combinationally
    assign tick = run && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/maneuver_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : maneuver_sequencer
// Description : Accepts motion commands over valid/ready, drives the 3-bit
//               motor mode, times turn/U-turn/rotate manoeuvres and pre-empts
//               motion on front obstacles, resuming once the path is clear.
//               Optional macro MANEUVER_QUEUE_EN adds a 2-entry command FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module maneuver_sequencer
    import maneuver_pkg::*;
#(
    parameter int TICK_DIV  = 100000,
    parameter int TURN_T    = 671,
    parameter int UTURN_T   = 2684,
    parameter int ROT_T     = 5369,
    parameter int BACKOFF_T = 200,
    parameter int OBST_CM   = 20,
    parameter int CNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [2:0]  cmd_code,
    output logic        cmd_ready,
    input  logic        abort,
    input  logic [19:0] distance,
    output logic [2:0]  mode,
    output logic        busy,
    output logic        paused,
    output logic        done
);

    localparam logic [19:0]      c_OBST_CM = 20'(OBST_CM);
    localparam logic [CNT_W-1:0] c_BACKOFF = CNT_W'(BACKOFF_T);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);
    localparam longint           c_LIMIT   = longint'(1) << CNT_W;

    if ((longint'(TURN_T) >= c_LIMIT) || (longint'(UTURN_T) >= c_LIMIT) ||
        (longint'(ROT_T) >= c_LIMIT) || (longint'(BACKOFF_T) >= c_LIMIT) ||
        (TURN_T < 0) || (UTURN_T < 0) || (ROT_T < 0) || (BACKOFF_T < 0) ||
        (TICK_DIV < 1)) begin : g_param_check
        $error("maneuver_sequencer: duration parameters must fit CNT_W and TICK_DIV >= 1");
    end

    state_t           r_state, w_state_nxt, r_resume, w_resume_nxt;
    cmd_t             r_cmd, w_cmd_nxt, w_start_cmd;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, r_bcnt, w_bcnt_nxt;
    logic             r_obst;
    logic             w_accept, w_start, w_tick, w_ps_run, w_ps_clear;
    logic [2:0]       r_mode;
    logic             r_busy, r_paused, r_done;

`ifdef MANEUVER_QUEUE_EN
    cmd_t       r_fifo [2];
    logic       r_rd_ptr, r_wr_ptr;
    logic [1:0] r_fifo_cnt;
    logic       w_fifo_full, w_fifo_empty, w_push, w_pop;
    cmd_t       w_fifo_head;

    assign w_fifo_full  = (r_fifo_cnt == 2'd2);
    assign w_fifo_empty = (r_fifo_cnt == 2'd0);
    assign w_fifo_head  = r_fifo[r_rd_ptr];
    assign cmd_ready    = !w_fifo_full && !abort;
    // Commands start directly only when nothing is already waiting ahead of them
    assign w_push = w_accept && !((r_state == ST_IDLE) ||
                                  ((r_state == ST_RUN_CONT) && w_fifo_empty));
`else
    assign cmd_ready = ((r_state == ST_IDLE) || (r_state == ST_RUN_CONT)) && !abort;
`endif

    assign w_accept = cmd_valid && cmd_ready;
    assign w_ps_run = (r_state == ST_RUN_TIMED) || (r_state == ST_BACKOFF);
    // Any state change restarts the tick phase so each phase gets whole ticks
    assign w_ps_clear = abort || !w_ps_run || (w_state_nxt != r_state);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (w_ps_clear),
        .run   (w_ps_run),
        .tick  (w_tick)
    );

    // Next-state, counter and command selection; abort overrides everything
    always_comb begin
        w_state_nxt  = r_state;
        w_resume_nxt = r_resume;
        w_cmd_nxt    = r_cmd;
        w_cnt_nxt    = r_cnt;
        w_bcnt_nxt   = r_bcnt;
        w_start      = 1'b0;
        w_start_cmd  = cmd_t'(cmd_code);
`ifdef MANEUVER_QUEUE_EN
        w_pop        = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                w_start = w_accept;
            end
            ST_RUN_CONT: begin
`ifdef MANEUVER_QUEUE_EN
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_start     = 1'b1;
                    w_start_cmd = w_fifo_head;
                end else
`endif
                if (w_accept) begin
                    w_start = 1'b1;
                end else if ((r_cmd == CMD_FWD) && r_obst) begin
                    w_state_nxt  = ST_HOLD;
                    w_resume_nxt = ST_RUN_CONT;
                end
            end
            ST_RUN_TIMED: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_DONE;
                end else if (r_obst) begin
                    w_state_nxt = ST_BACKOFF;
                    w_bcnt_nxt  = c_BACKOFF;
                end else if (w_tick) begin
                    w_cnt_nxt = r_cnt - c_ONE;
                    if (r_cnt == c_ONE) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_BACKOFF: begin
                if (r_bcnt == '0) begin
                    w_state_nxt  = ST_HOLD;
                    w_resume_nxt = ST_RUN_TIMED;
                end else if (w_tick) begin
                    w_bcnt_nxt = r_bcnt - c_ONE;
                    if (r_bcnt == c_ONE) begin
                        w_state_nxt  = ST_HOLD;
                        w_resume_nxt = ST_RUN_TIMED;
                    end
                end
            end
            ST_HOLD: begin
                if (!r_obst) begin
                    w_state_nxt = r_resume;
                end
            end
            ST_DONE: begin
`ifdef MANEUVER_QUEUE_EN
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_start     = 1'b1;
                    w_start_cmd = w_fifo_head;
                end else
`endif
                begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_start) begin
            w_cmd_nxt = w_start_cmd;
            case (w_start_cmd)
                CMD_STOP:          w_state_nxt = ST_DONE;
                CMD_FWD, CMD_BACK: w_state_nxt = ST_RUN_CONT;
                default: begin
                    w_state_nxt = ST_RUN_TIMED;
                    w_cnt_nxt   = CNT_W'(cmd_duration(w_start_cmd, TURN_T, UTURN_T, ROT_T));
                end
            endcase
        end

        if (abort) begin
            w_state_nxt  = ST_IDLE;
            w_resume_nxt = ST_IDLE;
            w_cmd_nxt    = CMD_STOP;
            w_cnt_nxt    = '0;
            w_bcnt_nxt   = '0;
            w_start      = 1'b0;
`ifdef MANEUVER_QUEUE_EN
            w_pop        = 1'b0;
`endif
        end
    end

    // State, counters and registered outputs derived from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_resume <= ST_IDLE;
            r_cmd    <= CMD_STOP;
            r_cnt    <= '0;
            r_bcnt   <= '0;
            r_obst   <= 1'b0;
            r_mode   <= c_MODE_STOP;
            r_busy   <= 1'b0;
            r_paused <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_resume <= w_resume_nxt;
            r_cmd    <= w_cmd_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bcnt   <= w_bcnt_nxt;
            r_obst   <= (distance < c_OBST_CM);
            r_mode   <= state_mode(w_state_nxt, w_cmd_nxt);
            r_busy   <= (w_state_nxt != ST_IDLE);
            r_paused <= (w_state_nxt == ST_BACKOFF) || (w_state_nxt == ST_HOLD);
            r_done   <= (w_state_nxt == ST_DONE);
        end
    end

`ifdef MANEUVER_QUEUE_EN
    // Two-entry command FIFO; abort flushes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fifo[0]  <= CMD_STOP;
            r_fifo[1]  <= CMD_STOP;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_fifo_cnt <= 2'd0;
        end else if (abort) begin
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_fifo_cnt <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= cmd_t'(cmd_code);
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end
`endif

    assign mode   = r_mode;
    assign busy   = r_busy;
    assign paused = r_paused;
    assign done   = r_done;

endmodule
`default_nettype wire
